// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel valid/ready stream multiplexer with one registered output stage.
// Build option STREAM_MUX_RR_EN selects round-robin arbitration; otherwise the sel port picks the channel.
module stream_mux_rr #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [SEL_W-1:0]          out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    logic [WIDTH-1:0]    out_data_reg;
    logic [SEL_W-1:0]    out_chan_reg;
    logic                out_valid_reg;
    logic                free;
    logic [CHANNELS-1:0] req;
    logic [CHANNELS-1:0] grant;
    logic                any_grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [WIDTH-1:0]    grant_data;

`ifdef STREAM_MUX_RR_EN
    logic [SEL_W-1:0]    last_reg;
    logic [CHANNELS-1:0] above_last;
    logic [CHANNELS-1:0] req_above;
    logic                unused_sel;

    assign unused_sel = ^sel;

    // Channels above the last winner take priority; if none are valid, wrap to the lowest valid one.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_above
            assign above_last[gi] = (SEL_W'(gi) > last_reg);
        end
    endgenerate

    assign req_above = in_valid & above_last;
    assign req       = (|req_above) ? req_above : in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg <= SEL_W'(CHANNELS - 1);
        end else if (free && any_grant) begin
            last_reg <= grant_idx;
        end
    end
`else
    logic [CHANNELS-1:0] sel_hit;

    // sel values beyond the last channel match no bit and therefore grant nothing.
    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_sel
            assign sel_hit[gi] = (sel == SEL_W'(gi));
        end
    endgenerate

    assign req = in_valid & sel_hit;
`endif

    // Isolate the lowest set request bit: the result is one-hot or zero.
    assign grant     = req & (~req + CHANNELS'(1));
    assign any_grant = |grant;
    assign free      = !out_valid_reg || out_ready;
    assign in_ready  = (rst || !free) ? '0 : grant;

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_chan_reg  <= '0;
        end else if (free) begin
            out_valid_reg <= any_grant;
            if (any_grant) begin
                out_data_reg <= grant_data;
                out_chan_reg <= grant_idx;
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_chan  = out_chan_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed testbench for stream_mux_rr (4 channels, 4-bit data); follows STREAM_MUX_RR_EN like the design.
module tb_stream_mux_rr;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [SEL_W-1:0]          sel;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    int checks_reg;
    int errors_reg;

    logic [3:0] chan_data [4];

    stream_mux_rr #(
        .WIDTH(WIDTH),
        .CHANNELS(CHANNELS),
        .SEL_W(SEL_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .sel(sel),
        .out_data(out_data),
        .out_chan(out_chan),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_reg++;
        if (got !== exp) begin
            errors_reg++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s got=%0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge, where outputs are stable.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [3:0] d, input logic [1:0] c);
        check_value({tag, ".valid"}, 32'(out_valid), 32'(v));
        check_value({tag, ".data"},  32'(out_data),  32'(d));
        check_value({tag, ".chan"},  32'(out_chan),  32'(c));
    endtask

    initial begin
        checks_reg   = 0;
        errors_reg   = 0;
        chan_data[0] = 4'h3;
        chan_data[1] = 4'h5;
        chan_data[2] = 4'hA;
        chan_data[3] = 4'hC;
        in_data      = {4'hC, 4'hA, 4'h5, 4'h3};
        in_valid     = 4'hF;
        sel          = 2'd0;
        out_ready    = 1'b1;
        rst          = 1'b1;

        // Reset with every channel requesting
        #1;
        check_value("rst.in_ready0", 32'(in_ready), 32'h0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_out("rst", 1'b0, 4'h0, 2'd0);
            check_value("rst.in_ready", 32'(in_ready), 32'h0);
        end
        rst = 1'b0;

`ifndef STREAM_MUX_RR_EN
        // Fixed-mode sweep, one word per cycle
        for (int s = 0; s < 4; s++) begin
            sel = 2'(s);
            #1;
            check_value("sweep.in_ready", 32'(in_ready), 32'(1 << s));
            tick();
            check_out("sweep", 1'b1, chan_data[s], 2'(s));
        end
        // Nothing valid: out_valid drops, data and chan hold
        in_valid = 4'h0;
        #1;
        check_value("idle.in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("idle", 1'b0, 4'hC, 2'd3);
        in_valid = 4'hF;
        sel      = 2'd1;
        tick();
        check_out("bp.first", 1'b1, 4'h5, 2'd1);
        sel = 2'd2;
`else
        // Round-robin fairness with all channels valid
        for (int k = 0; k < 8; k++) begin
            #1;
            check_value("rr.in_ready", 32'(in_ready), 32'(1 << (k % 4)));
            tick();
            check_out("rr.fair", 1'b1, chan_data[k % 4], 2'(k % 4));
        end
        // Skip idle channels and wrap around
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_out("rr.skip", 1'b1, chan_data[(k % 2) ? 3 : 1], 2'((k % 2) ? 3 : 1));
        end
        in_valid = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            check_out("rr.solo", 1'b1, 4'h3, 2'd0);
        end
        in_valid = 4'hF;
        sel      = 2'd3;
        tick();
        check_out("bp.first", 1'b1, 4'h5, 2'd1);
`endif

        // Backpressure: hold for three cycles, then load on the draining edge
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_value("bp.in_ready", 32'(in_ready), 32'h0);
            tick();
            check_out("bp.hold", 1'b1, 4'h5, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        check_value("bp.release_ready", 32'(in_ready), 32'h4);
        tick();
        check_out("bp.next", 1'b1, 4'hA, 2'd2);

        // Reset while a word is stalled in the register
        out_ready = 1'b0;
        rst       = 1'b1;
        #1;
        check_value("mrst.in_ready", 32'(in_ready), 32'h0);
        tick();
        check_out("mrst", 1'b0, 4'h0, 2'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
`ifndef STREAM_MUX_RR_EN
        sel = 2'd0;
`endif
        #1;
        check_value("mrst.grant", 32'(in_ready), 32'h1);
        tick();
        check_out("mrst.first", 1'b1, 4'h3, 2'd0);

        $display("CHECKS %0d ERRORS %0d", checks_reg, errors_reg);
        $finish;
    end

endmodule
